// File: rtl/fewcore_mem_pkg.sv
// Shared opcode/funct3 constants and FSM state type for the fewcore memory stage.
// Also provides the funct3 legality check used when an op is accepted.
package fewcore_mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Combinational byte-lane steering: store byte enables/replicated data, load data
// packed toward the MSB end, and the misalignment flag for the access size.
module mem_lane_format
    import fewcore_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;

    assign w_shifted = i_mem_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be         = 4'h0;
        o_wdata      = i_store_data;
        o_load_data  = i_mem_rdata;
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {w_shifted[7:0], 24'h0};
            end
            F3_H, F3_HU: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {w_shifted[15:0], 16'h0};
                o_misaligned = i_addr_lo[0];
            end
            F3_W: begin
                o_be         = 4'hF;
                o_misaligned = |i_addr_lo;
            end
            default: o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// fewcore data-memory access stage: runs loads/stores on a req/gnt/rvalid bus.
// Define MEM_TIMEOUT_EN to enable the bus watchdog (TIMEOUT_CYCLES).
module mem_access
    import fewcore_mem_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    output logic [XLEN-1:0] memData,
    output logic [4:0]      wb_rd,
    output logic            done,
    output logic            busy,
    output logic            access_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    mem_state_e      r_state, w_state_d;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [4:0]      r_rd, r_wb_rd;
    logic [XLEN-1:0] r_mem_data, r_mem_addr, r_mem_wdata;
    logic [3:0]      r_mem_be;
    logic            r_mem_we, r_done, r_err;

    logic            w_is_load, w_is_store, w_is_mem, w_legal, w_misaligned;
    logic            w_accept, w_reject, w_timeout, w_abort, w_unused_op;
    logic [2:0]      w_fmt_funct3;
    logic [1:0]      w_fmt_addr_lo;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata, w_load_data;

    assign w_is_load   = operation[6:0] == OPC_LOAD;
    assign w_is_store  = operation[6:0] == OPC_STORE;
    assign w_is_mem    = w_is_load || w_is_store;
    assign w_legal     = f3_legal(w_is_store, operation[9:7]);
    assign w_unused_op = ^operation[11:10];

    // Live op drives the formatter while idle; the latched op drives it for load return.
    assign w_fmt_funct3  = (r_state == IDLE) ? operation[9:7] : r_funct3;
    assign w_fmt_addr_lo = (r_state == IDLE) ? addr[1:0] : r_addr_lo;

    assign w_accept = (r_state == IDLE) && op_valid && w_is_mem && w_legal && !w_misaligned;
    assign w_reject = (r_state == IDLE) && op_valid && w_is_mem && (!w_legal || w_misaligned);

    mem_lane_format u_lane_format (
        .i_funct3     (w_fmt_funct3),
        .i_addr_lo    (w_fmt_addr_lo),
        .i_store_data (store_data),
        .i_mem_rdata  (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TmoW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || (w_state_d != r_state)) begin
            r_tmo_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
        end
    end

    assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out; the parameter stays so instantiations need not change.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign w_abort = w_timeout && ((r_state == REQ) ? !mem_gnt : !mem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_d = REQ;
            REQ: begin
                if (mem_gnt) begin
                    w_state_d = r_mem_we ? IDLE : WAIT;
                end else if (w_abort) begin
                    w_state_d = IDLE;
                end
            end
            WAIT:    if (mem_rvalid || w_abort) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        busy    = 1'b0;
        case (r_state)
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            WAIT:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_rd        <= '0;
            r_wb_rd     <= '0;
            r_mem_data  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject || w_abort;
            if (w_accept) begin
                r_mem_addr  <= {addr[XLEN-1:2], 2'b00};
                r_mem_we    <= w_is_store;
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_rd        <= rd_in;
                r_funct3    <= operation[9:7];
                r_addr_lo   <= addr[1:0];
            end
            if ((r_state == REQ) && mem_gnt && r_mem_we) begin
                r_done <= 1'b1;
            end
            if ((r_state == WAIT) && mem_rvalid) begin
                r_mem_data <= w_load_data;
                r_wb_rd    <= r_rd;
                r_done     <= 1'b1;
            end
        end
    end

    assign memData    = r_mem_data;
    assign wb_rd      = r_wb_rd;
    assign done       = r_done;
    assign access_err = r_err;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized ops against a behavioural memory-op model,
// with a bus responder and a completion monitor decoupled from the stimulus driver.
module tb_mem_access;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    typedef struct {
        bit          is_err;
        bit          is_load;
        logic [31:0] data;
        logic [4:0]  rd;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned gd;
        int unsigned re;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [11:0] operation;
    logic [31:0] addr, store_data, memData, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  rd_in, wb_rd;
    logic        done, busy, access_err, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;

    exp_t        sq[$];
    bus_t        bq[$];
    logic [31:0] exp_md;
    logic [4:0]  exp_rd;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 0;
    bit          auto_bus = 1;
    exp_t        m_e;
    bus_t        r_b;

    mem_access #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .operation  (operation),
        .addr       (addr),
        .store_data (store_data),
        .rd_in      (rd_in),
        .memData    (memData),
        .wb_rd      (wb_rd),
        .done       (done),
        .busy       (busy),
        .access_err (access_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Completion monitor: pops the scoreboard whenever done or access_err pulses.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (done || access_err) begin
                chk(!(done && access_err), "done_err_exclusive", {30'd0, done, access_err}, 0);
                if (sq.size() == 0) begin
                    chk(0, "unexpected_completion", {30'd0, done, access_err}, 0);
                end else begin
                    m_e = sq.pop_front();
                    chk(m_e.is_err ? (access_err && !done) : (done && !access_err),
                        "completion_kind", {30'd0, done, access_err},
                        m_e.is_err ? 32'd1 : 32'd2);
                    chk(cyc == m_e.cyc, "completion_cycle", cyc, m_e.cyc);
                    if (!m_e.is_err && m_e.is_load) begin
                        exp_md = m_e.data;
                        exp_rd = m_e.rd;
                    end
                end
            end
            chk(memData == exp_md, "memData", memData, exp_md);
            chk(wb_rd == exp_rd, "wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
        end
    end

    // Bus responder: checks the request against the model, then grants/returns data.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (auto_bus && !reset && mem_req) begin
                if (bq.size() == 0) begin
                    chk(0, "unexpected_mem_req", {31'd0, mem_req}, 0);
                end else begin
                    r_b = bq.pop_front();
                    chk(busy, "busy_in_req", {31'd0, busy}, 1);
                    chk(mem_addr == r_b.addr, "mem_addr", mem_addr, r_b.addr);
                    chk(mem_we == r_b.we, "mem_we", {31'd0, mem_we}, {31'd0, r_b.we});
                    chk(mem_be == r_b.be, "mem_be", {28'd0, mem_be}, {28'd0, r_b.be});
                    chk(mem_wdata == r_b.wdata, "mem_wdata", mem_wdata, r_b.wdata);
                    for (int i = 0; i < int'(r_b.gd); i++) begin
                        @(negedge clk);
                        chk(mem_req && mem_addr == r_b.addr && mem_be == r_b.be &&
                            mem_wdata == r_b.wdata && mem_we == r_b.we,
                            "req_held_until_gnt", {31'd0, mem_req}, 1);
                    end
                    mem_gnt = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_gnt = 1'b0;
                    chk(!mem_req, "req_drop_after_gnt", {31'd0, mem_req}, 0);
                    if (!r_b.we) begin
                        repeat (r_b.re) begin
                            @(posedge clk);
                            #1;
                        end
                        mem_rvalid = 1'b1;
                        mem_rdata  = r_b.rdata;
                        @(posedge clk);
                        #1;
                        mem_rvalid = 1'b0;
                        mem_rdata  = $urandom;
                    end
                end
            end
        end
    end

    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Issue one op, record the model's expectation, wait for it to complete.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                          input int unsigned gd, input int unsigned re);
        exp_t        e;
        bus_t        b;
        int unsigned sz, k;
        bit          is_ld, is_st, legal;
        logic [31:0] sh, m;
        logic [1:0]  hi;
        @(posedge clk);
        #1;
        hi         = 2'($urandom_range(0, 3));
        op_valid   = 1'b1;
        operation  = {hi, f3, opc};
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        is_ld      = (opc == LD);
        is_st      = (opc == ST);
        sz         = acc_size(f3);
        legal      = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                           : (f3 inside {3'd0, 3'd1, 3'd2});
        k          = a % 4;
        e.rd       = rd;
        e.data     = '0;
        e.is_load  = is_ld;
        if (is_ld || is_st) begin
            if (!legal || (a % sz) != 0) begin
                e.is_err = 1;
                e.cyc    = cyc + 1;
                sq.push_back(e);
            end else begin
                m       = ((32'd1 << sz) - 1) << k;
                b.addr  = a & ~32'd3;
                b.we    = is_st;
                b.be    = m[3:0];
                b.wdata = (sz == 1) ? sd[7:0] * 32'h0101_0101 :
                          (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
                b.rdata = rdata;
                b.gd    = gd;
                b.re    = re;
                bq.push_back(b);
                sh      = rdata >> (8 * k);
                e.data  = (sz == 1) ? sh << 24 : (sz == 2) ? sh << 16 : rdata;
                e.is_err = 0;
                e.cyc   = cyc + (is_st ? 2 + gd : 3 + gd + re);
                sq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        op_valid   = 1'b0;
        operation  = 12'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        rd_in      = 5'($urandom);
        for (int i = 0; i < 100 && sq.size() != 0; i++) @(posedge clk);
        if (sq.size() != 0) begin
            chk(0, "completion_bound", sq.size(), 0);
            sq.delete();
            bq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic random_ops(input int count);
        logic [6:0]  opc;
        logic [31:0] a;
        int unsigned sel;
        for (int n = 0; n < count; n++) begin
            sel = $urandom_range(0, 9);
            opc = (sel < 5) ? LD : (sel < 9) ? ST : 7'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(opc, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_md = '0;
        exp_rd = '0;
        sq.delete();
        bq.delete();
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        op_valid   = 1'b0;
        operation  = '0;
        addr       = '0;
        store_data = '0;
        rd_in      = '0;
        exp_md     = '0;
        exp_rd     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk({memData, mem_addr, mem_wdata} == '0, "reset_data_zero", memData | mem_addr, 0);
        chk({wb_rd, done, busy, access_err, mem_req, mem_we, mem_be} == '0, "reset_ctrl_zero",
            {15'd0, wb_rd, done, busy, access_err, mem_req, mem_we, mem_be}, 0);
        mon_en = 1;

        run_op(ST, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3, 32'h0, 0, 0);
        run_op(LD, 3'b000, 32'h203, 32'h0, 5'd17, 32'h8011_2233, 0, 0);
        run_op(ST, 3'b001, 32'h12, 32'h0000_ABCD, 5'd4, 32'h0, 3, 0);
        run_op(LD, 3'b010, 32'h101, 32'h0, 5'd5, 32'h0, 0, 0);
        run_op(LD, 3'b011, 32'h0, 32'h0, 5'd6, 32'h0, 0, 0);
        run_op(7'b0110011, 3'b000, 32'h40, 32'h0, 5'd7, 32'h0, 0, 0);
        run_op(LD, 3'b101, 32'h22, 32'h0, 5'd8, 32'hA1B2_C3D4, 1, 2);

        // Reset while a load sits in WAIT; the late rvalid must be ignored.
        auto_bus = 0;
        @(posedge clk);
        #1;
        op_valid  = 1'b1;
        operation = {2'b00, 3'b000, LD};
        addr      = 32'h40;
        rd_in     = 5'd9;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk(mem_req, "rst_test_req", {31'd0, mem_req}, 1);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        chk(busy && !mem_req, "rst_test_wait_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_md = '0;
        exp_rd = '0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = (i == 1);
            mem_rdata  = 32'hCAFE_F00D;
            chk(!busy && !done && !mem_req, "rst_late_rvalid_ignored",
                {29'd0, busy, done, mem_req}, 0);
            @(posedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
        auto_bus   = 1;

`ifdef MEM_TIMEOUT_EN
        begin
            exp_t te;
            auto_bus = 0;
            @(posedge clk);
            #1;
            op_valid   = 1'b1;
            operation  = {2'b00, 3'b010, ST};
            addr       = 32'h300;
            store_data = 32'h1234_5678;
            te.is_err  = 1;
            te.is_load = 0;
            te.data    = '0;
            te.rd      = '0;
            te.cyc     = cyc + 9;
            sq.push_back(te);
            @(posedge clk);
            #1;
            op_valid = 1'b0;
            n = 0;
            for (int i = 0; i < 20; i++) begin
                if (mem_req) n++;
                @(posedge clk);
                #1;
            end
            chk(n == 8, "timeout_req_cycles", n, 8);
            chk(sq.size() == 0, "timeout_err_seen", sq.size(), 0);
            sq.delete();
            auto_bus = 1;
        end
`endif

        random_ops(150);
        do_reset();
        run_op(LD, 3'b001, 32'h2, 32'h0, 5'd30, 32'h1122_3344, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_bound: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
